booth_seq_hilo: RTL and testbench

- Sequential radix-4 (Booth-2) multiply engine in the ALU, directly downstream of the combinational Booth encoder/partial-product stage.
- Retires one Booth group per cycle:
  - decodes the multiplier triplet,
  - selects the partial product from {0, ±B, ±2B},
  - adds it, shifted, into a wide accumulator.
- Commits the 2*DATA_WIDTH product into the architectural HI/LO registers.
- Serves MULT/MULTU, plus MTHI/MTLO writes from the pipeline.

---
 rtl/booth_seq_hilo.sv | 136 +++++++++++++
 tb/tb_booth_seq_hilo.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/booth_seq_hilo.sv
// Sequential radix-4 Booth multiplier that retires one group per cycle and commits results to HI/LO.
// Define MUL_MADD_EN to enable MADD/MSUB (accumulator preloaded from {hi,lo}).
module booth_seq_hilo #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  signed_op,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  flush,
  input  logic                  hi_we,
  input  logic                  lo_we,
  input  logic [DATA_WIDTH-1:0] hilo_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int BOOTH_NUM = (DATA_WIDTH + 2) / 2;
  localparam int EW        = DATA_WIDTH + 2;
  localparam int AW        = 2 * DATA_WIDTH + 4;
  localparam int CW        = $clog2(BOOTH_NUM);
  localparam logic [CW-1:0] LAST = CW'(BOOTH_NUM - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t        state, state_next;
  logic [CW-1:0] count;
  logic [EW:0]   a_sr;     // {a_ext, 1'b0}; the current triplet always sits in bits [2:0]
  logic [AW-1:0] b_sh;     // sign-extended multiplicand, pre-shifted to the current group offset
  logic [AW-1:0] acc;
  logic [AW-1:0] pp;
  logic [AW-1:0] acc_sum;
  logic [AW-1:0] acc_init;
  logic [EW-1:0] a_ext, b_ext, b_init;
  logic          accept, finish;

  always_comb begin
    a_ext = signed_op ? {{2{a[DATA_WIDTH-1]}}, a} : {2'b00, a};
    b_ext = signed_op ? {{2{b[DATA_WIDTH-1]}}, b} : {2'b00, b};
  end

`ifdef MUL_MADD_EN
  logic unused_op;
  assign unused_op = op[0];
  // MSUB negates the multiplicand once at latch time; EW bits hold -b without overflow.
  assign b_init   = (op == 2'b11) ? ('0 - b_ext) : b_ext;
  assign acc_init = op[1] ? {4'b0000, hi, lo} : '0;
`else
  logic unused_op;
  assign unused_op = ^op;
  assign b_init   = b_ext;
  assign acc_init = '0;
`endif

  always_comb begin
    // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
    pp = '0;
    unique case (a_sr[2:0])
      3'b001, 3'b010: pp = b_sh;
      3'b011:         pp = b_sh << 1;
      3'b100:         pp = '0 - (b_sh << 1);
      3'b101, 3'b110: pp = '0 - b_sh;
      default:        pp = '0;
    endcase
    acc_sum = acc + pp;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !flush) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        if (flush) begin
          state_next = IDLE;
        end else if (count == LAST) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == CALC);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are cleared too so no stale operand survives a reset.
      state <= IDLE;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      acc   <= '0;
      count <= '0;
      a_sr  <= '0;
      b_sh  <= '0;
    end else begin
      state <= state_next;
      done  <= finish;

      if (accept) begin
        a_sr  <= {a_ext, 1'b0};
        b_sh  <= {{(AW-EW){b_init[EW-1]}}, b_init};
        acc   <= acc_init;
        count <= '0;
      end else if (state == CALC) begin
        a_sr  <= a_sr >> 2;
        b_sh  <= b_sh << 2;
        acc   <= acc_sum;
        count <= count + 1'b1;
      end

      // Completion outranks a same-cycle MTHI/MTLO write.
      if (finish) begin
        {hi, lo} <= acc_sum[2*DATA_WIDTH-1:0];
      end else begin
        if (hi_we) hi <= hilo_wdata;
        if (lo_we) lo <= hilo_wdata;
      end
    end
  end

endmodule

// File: tb/tb_booth_seq_hilo.sv
// Scoreboard bench for booth_seq_hilo: the driver pushes expected HI/LO and done cycle; a monitor checks each done.
module tb_booth_seq_hilo;

  logic        clk = 1'b0;
  logic        rst, start, signed_op, flush, hi_we, lo_we;
  logic [1:0]  op;
  logic [31:0] a, b, hilo_wdata;
  logic        busy, done;
  logic [31:0] hi, lo;

  booth_seq_hilo #(.DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_op(signed_op), .op(op),
    .a(a), .b(b), .flush(flush), .hi_we(hi_we), .lo_we(lo_we),
    .hilo_wdata(hilo_wdata), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic logic [63:0] model(input logic [31:0] ma, input logic [31:0] mb,
                                        input logic ms, input logic [1:0] mop,
                                        input logic [31:0] mh, input logic [31:0] ml);
    logic [63:0] ea, eb, p;
    ea = ms ? {{32{ma[31]}}, ma} : {32'h0, ma};
    eb = ms ? {{32{mb[31]}}, mb} : {32'h0, mb};
    p  = ea * eb;
`ifdef MUL_MADD_EN
    if (mop == 2'b10) return {mh, ml} + p;
    if (mop == 2'b11) return {mh, ml} - p;
`endif
    return p;
  endfunction

  // Monitor: every done pulse must match the oldest expected entry.
  exp_t mon_e;
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'd1, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check("done_hi", {32'h0, hi}, {32'h0, mon_e.hi});
        check("done_lo", {32'h0, lo}, {32'h0, mon_e.lo});
        check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  task automatic launch(input logic [31:0] ta, input logic [31:0] tb_v,
                        input logic ts, input logic [1:0] top, output logic [63:0] r);
    exp_t e;
    r     = model(ta, tb_v, ts, top, m_hi, m_lo);
    e.hi  = r[63:32];
    e.lo  = r[31:0];
    e.cyc = cyc + 18;
    sb.push_back(e);
    a = ta; b = tb_v; signed_op = ts; op = top; start = 1'b1;
  endtask

  task automatic scramble();
    start = 1'b0; a = $urandom; b = $urandom; signed_op = 1'($urandom); op = 2'($urandom);
  endtask

  task automatic do_op(input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic ts, input logic [1:0] top);
    logic [63:0] r;
    int nb;
    bit seen;
    launch(ta, tb_v, ts, top, r);
    @(negedge clk);
    scramble();
    nb = 0; seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (busy) nb++;
      if (done) seen = 1;
      else @(negedge clk);
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
    check("busy_cycles", 64'(nb), 64'd17);
    m_hi = r[63:32];
    m_lo = r[31:0];
  endtask

  task automatic idle_write(input bit to_hi, input logic [31:0] d);
    hi_we = to_hi; lo_we = !to_hi; hilo_wdata = d;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    if (to_hi) begin m_hi = d; check("mthi", {32'h0, hi}, {32'h0, d}); end
    else       begin m_lo = d; check("mtlo", {32'h0, lo}, {32'h0, d}); end
  endtask

  logic [63:0] r;
  logic [31:0] corner [5];

  initial begin
    rst = 1'b1; start = 1'b0; signed_op = 1'b0; op = 2'b00; a = '0; b = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; hilo_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", {63'h0, busy}, 64'd0);
    check("rst_done", {63'h0, done}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);

    // Directed products
    do_op(32'h0000_0003, 32'hFFFF_FFFB, 1'b1, 2'b00);
    check("m3x5_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2'b00);
    check("umax_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 2'b00);
    check("sneg1_hilo", {hi, lo}, 64'h0000_0000_0000_0001);
    do_op(32'h8000_0000, 32'h8000_0000, 1'b1, 2'b00);
    check("smin_sq_hilo", {hi, lo}, 64'h4000_0000_0000_0000);
    do_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 2'b00);
    check("smax_smin_hilo", {hi, lo}, 64'hC000_0000_8000_0000);

    // Ignored start while busy, then flush
    @(negedge clk);
    idle_write(1'b1, 32'h1111_1111);
    a = 32'd5; b = 32'd7; signed_op = 1'b1; op = 2'b00; start = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      start = (i == 3);
      if (i == 3) begin a = 32'd9; b = 32'd9; end
      flush = (i == 5);
    end
    check("flush_busy", {63'h0, busy}, 64'd0);
    check("flush_done", {63'h0, done}, 64'd0);
    check("flush_hi", {32'h0, hi}, 64'h1111_1111);
    repeat (25) @(negedge clk);
    check("flush_idle_busy", {63'h0, busy}, 64'd0);
    do_op(32'd5, 32'd7, 1'b1, 2'b00);
    check("after_flush_lo", {32'h0, lo}, 64'h23);

    // Reset mid-operation discards the result
    idle_write(1'b0, 32'h1234_5678);
    a = 32'h0001_0001; b = 32'h0000_0100; signed_op = 1'b0; op = 2'b00; start = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      start = 1'b0;
      rst = (i == 8);
    end
    check("midrst_busy", {63'h0, busy}, 64'd0);
    check("midrst_done", {63'h0, done}, 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);
    m_hi = '0; m_lo = '0;
    repeat (25) @(negedge clk);

    // MTHI/MTLO in the final CALC cycle loses to completion
    launch(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 2'b00, r);
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 1) scramble();
      if (i == 17) begin hi_we = 1'b1; lo_we = 1'b1; hilo_wdata = 32'hAAAA_AAAA; end
    end
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    check("wr_vs_done_flag", {63'h0, done}, 64'd1);
    check("wr_vs_done_hilo", {hi, lo}, r);
    m_hi = r[63:32]; m_lo = r[31:0];

    // MADD / MSUB (plain multiply when the feature is absent)
    @(negedge clk);
    idle_write(1'b1, 32'h0);
    idle_write(1'b0, 32'h5);
    do_op(32'd2, 32'd3, 1'b1, 2'b10);
`ifdef MUL_MADD_EN
    check("madd_lo", {hi, lo}, 64'h0000_0000_0000_000B);
    do_op(32'd4, 32'd4, 1'b1, 2'b11);
    check("msub_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFB);
`else
    check("madd_off_lo", {hi, lo}, 64'h0000_0000_0000_0006);
`endif

    // Random back-to-back operations with occasional MTHI/MTLO
    corner[0] = 32'h0; corner[1] = 32'h8000_0000; corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h7FFF_FFFF; corner[4] = 32'h1;
    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 3) == 0) idle_write(1'($urandom), $urandom);
      do_op(ra, rb, 1'($urandom), 2'($urandom));
    end

    repeat (3) @(negedge clk);
    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
